ex_cond_unit: RTL

Execute-stage consumer of the ID/EX pipeline register in the pipelined ARM core. Evaluates each instruction's 4-bit condition field against the architectural NZCV flag register and updates the flags per FlagWriteE. It gates RegWrite/MemWrite/PCSrc and squashes the two wrong-path instructions that follow a taken PC write. Registers surviving control and data into the EX/MEM stage.

---
 rtl/ex_cond_unit_pkg.sv | 36 +++
 rtl/ex_cond_unit_if.sv | 42 ++++
 rtl/ex_cond_unit_cond_check.sv | 39 +++
 rtl/ex_cond_unit.sv | 139 +++++++++++++
 4 files changed

// File: rtl/ex_cond_unit_pkg.sv
// ex_pkg: shared types for the execute-stage condition unit.
// ARM condition codes, squash FSM states and NZCV bit positions.
package ex_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    typedef enum logic [1:0] {
        RUN = 2'd0,
        SQ1 = 2'd1,
        SQ2 = 2'd2
    } sq_state_e;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/ex_cond_unit_if.sv
// ex_cond_unit_if: ID/EX instruction bundle in, EX/MEM bundle out.
// master = surrounding pipeline, slave = execute condition unit.
interface ex_cond_unit_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 4
);
    // ID/EX side
    logic              ValidE;
    logic [3:0]        CondE;
    logic [1:0]        FlagWriteE;
    logic [3:0]        ALUFlagsE;
    logic              PCSrcE;
    logic              RegWriteE;
    logic              MemWriteE;
    logic              MemtoRegE;
    logic [DATA_W-1:0] ALUResultE;
    logic [DATA_W-1:0] WriteDataE;
    logic [REG_AW-1:0] WA3E;
    // EX/MEM side
    logic              ValidM;
    logic              RegWriteM;
    logic              MemWriteM;
    logic              MemtoRegM;
    logic [DATA_W-1:0] ALUResultM;
    logic [DATA_W-1:0] WriteDataM;
    logic [REG_AW-1:0] WA3M;

    modport master (
        output ValidE, CondE, FlagWriteE, ALUFlagsE, PCSrcE, RegWriteE,
               MemWriteE, MemtoRegE, ALUResultE, WriteDataE, WA3E,
        input  ValidM, RegWriteM, MemWriteM, MemtoRegM, ALUResultM,
               WriteDataM, WA3M
    );

    modport slave (
        input  ValidE, CondE, FlagWriteE, ALUFlagsE, PCSrcE, RegWriteE,
               MemWriteE, MemtoRegE, ALUResultE, WriteDataE, WA3E,
        output ValidM, RegWriteM, MemWriteM, MemtoRegM, ALUResultM,
               WriteDataM, WA3M
    );

endinterface

// File: rtl/ex_cond_unit_cond_check.sv
// cond_check: pure combinational ARM condition evaluation against NZCV.
// Codes AL and 4'b1111 always pass.
module cond_check
    import ex_pkg::*;
(
    input  logic [3:0] i_flags,
    input  logic [3:0] i_cond,
    output logic       o_pass
);

    logic w_n, w_z, w_c, w_v;

    // Decode the condition field against the current flags
    always_comb begin
        w_n    = i_flags[FLAG_N];
        w_z    = i_flags[FLAG_Z];
        w_c    = i_flags[FLAG_C];
        w_v    = i_flags[FLAG_V];
        o_pass = 1'b1;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = ~w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = ~w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = ~w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = ~w_v;
            COND_HI: o_pass = w_c & ~w_z;
            COND_LS: o_pass = ~w_c | w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = ~w_z & (w_n == w_v);
            COND_LE: o_pass = w_z | (w_n != w_v);
            default: o_pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_cond_unit.sv
// ex_cond_unit: execute-stage condition evaluation, NZCV flag register,
// wrong-path squash FSM and EX/MEM pipeline register.
// Optional macro EX_COND_PERF_EN adds ExecCount/SquashCount counters.
module ex_cond_unit
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          StallE,
    input  logic          FlushE,
    ex_cond_unit_if.slave bus,
    output logic          CondExE,
    output logic          PCSrcTakenE,
    output logic [3:0]    FlagsQ
`ifdef EX_COND_PERF_EN
    ,
    output logic [31:0]   ExecCount,
    output logic [31:0]   SquashCount
`endif
);

    sq_state_e         r_state;
    sq_state_e         w_state_nxt;
    logic [3:0]        r_flags;
    logic              w_pass;
    logic              w_live;
    logic              w_advance;

    logic              r_valid_m;
    logic              r_reg_write_m;
    logic              r_mem_write_m;
    logic              r_mem_to_reg_m;
    logic [DATA_W-1:0] r_alu_result_m;
    logic [DATA_W-1:0] r_write_data_m;
    logic [REG_AW-1:0] r_wa3_m;

    cond_check u_cond_check (
        .i_flags (r_flags),
        .i_cond  (bus.CondE),
        .o_pass  (w_pass)
    );

    // Squash FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Liveness, gated redirect and squash FSM next state
    always_comb begin
        w_live      = bus.ValidE & ~FlushE & (r_state == RUN);
        CondExE     = w_live & w_pass;
        PCSrcTakenE = bus.PCSrcE & CondExE;
        // Only real, unstalled, non-flushed slots count as a squashed slot
        w_advance   = ~StallE & bus.ValidE & ~FlushE;
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (PCSrcTakenE && !StallE) w_state_nxt = SQ1;
            SQ1:     if (w_advance)              w_state_nxt = SQ2;
            SQ2:     if (w_advance)              w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    // Architectural NZCV: only passing, unstalled instructions write
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_flags <= '0;
        end else if (CondExE && !StallE) begin
            if (bus.FlagWriteE[1]) begin
                r_flags[FLAG_N] <= bus.ALUFlagsE[FLAG_N];
                r_flags[FLAG_Z] <= bus.ALUFlagsE[FLAG_Z];
            end
            if (bus.FlagWriteE[0]) begin
                r_flags[FLAG_C] <= bus.ALUFlagsE[FLAG_C];
                r_flags[FLAG_V] <= bus.ALUFlagsE[FLAG_V];
            end
        end
    end

    // EX/MEM pipeline register with condition-gated side effects
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid_m      <= 1'b0;
            r_reg_write_m  <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_mem_to_reg_m <= 1'b0;
            r_alu_result_m <= '0;
            r_write_data_m <= '0;
            r_wa3_m        <= '0;
        end else if (!StallE) begin
            r_valid_m      <= CondExE;
            r_reg_write_m  <= bus.RegWriteE & CondExE;
            r_mem_write_m  <= bus.MemWriteE & CondExE;
            r_mem_to_reg_m <= bus.MemtoRegE;
            r_alu_result_m <= bus.ALUResultE;
            r_write_data_m <= bus.WriteDataE;
            r_wa3_m        <= bus.WA3E;
        end
    end

    assign FlagsQ         = r_flags;
    assign bus.ValidM     = r_valid_m;
    assign bus.RegWriteM  = r_reg_write_m;
    assign bus.MemWriteM  = r_mem_write_m;
    assign bus.MemtoRegM  = r_mem_to_reg_m;
    assign bus.ALUResultM = r_alu_result_m;
    assign bus.WriteDataM = r_write_data_m;
    assign bus.WA3M       = r_wa3_m;

`ifdef EX_COND_PERF_EN
    logic [31:0] r_exec_count;
    logic [31:0] r_squash_count;

    // Executed and squashed (cond-failed or FSM-killed) instruction counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_exec_count   <= '0;
            r_squash_count <= '0;
        end else if (!StallE) begin
            if (CondExE) begin
                r_exec_count <= r_exec_count + 32'd1;
            end else if (bus.ValidE && !FlushE) begin
                r_squash_count <= r_squash_count + 32'd1;
            end
        end
    end

    assign ExecCount   = r_exec_count;
    assign SquashCount = r_squash_count;
`endif

endmodule
